// File: rtl/sdi_frame_rx_if.sv
// Word-side handshake of the serial frame receiver: received word, parity flag
// and the valid/ready pair between the receiver (master) and its consumer (slave).
interface sdi_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             READY;
  logic             PERR;

  modport master (output Q, output VALID, output PERR, input READY);
  modport slave  (input Q, input VALID, input PERR, output READY);
endinterface

// File: rtl/sdi_frame_rx.sv
// Capture end of a one-bit-per-cycle serial link launched on the falling clock edge:
// deframes start/data/parity/stop and holds each good word in a one-entry valid/ready register.
module sdi_frame_rx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               D,
  sdi_frame_rx_if.master     bus,
  output logic               FERR,
  output logic               OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAR  = 3'd2,
    S_STOP = 3'd3,
    S_BRK  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_perr;
  logic             r_ferr;
  logic             r_ovf;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_par_nxt;
  logic             w_stop_good;
  logic             w_stop_bad;
  logic             w_perr;
  logic             w_load;
  logic             w_drop;
  logic             w_consume;

  // Deframer state, bit counter, shift register and received parity bit.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Next-state logic; STOP flags a good or bad stop bit for the holding stage.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!D) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        w_shift_nxt[r_cnt] = D;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (PARITY_EN != 0) ? S_PAR : S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_PAR: begin
        w_par_nxt   = D;
        w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (D) begin
          w_stop_good = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stop_bad  = 1'b1;
          w_state_nxt = S_BRK;
        end
      end
      // A line held low after a bad stop must return high before a new start counts.
      S_BRK: begin
        if (D) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BRK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_perr    = (PARITY_EN != 0) ? ((^r_shift) ^ r_par) : 1'b0;
  assign w_load    = w_stop_good & (~r_valid | bus.READY);
  assign w_drop    = w_stop_good & r_valid & ~bus.READY;
  assign w_consume = r_valid & bus.READY;

  // Holding register, framing-error pulse and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      if (w_load) begin
        r_q     <= r_shift;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  assign bus.Q     = r_q;
  assign bus.VALID = r_valid;
  assign bus.PERR  = r_perr;
  assign FERR      = r_ferr;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_sdi_frame_rx.sv
// Scenario bench for sdi_frame_rx: an 8-bit parity instance and a 5-bit no-parity instance
// share clock and reset; expected words go through a scoreboard queue.
module tb_sdi_frame_rx;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  logic D8  = 1'b1;
  logic D5  = 1'b1;
  logic FERR8, OVF8, FERR5, OVF5;

  sdi_frame_rx_if #(.WIDTH(8)) if8 ();
  sdi_frame_rx_if #(.WIDTH(5)) if5 ();

  sdi_frame_rx #(.WIDTH(8), .PARITY_EN(1)) u_dut8 (
    .CLK(CLK), .RN(RN), .D(D8), .bus(if8.master), .FERR(FERR8), .OVF(OVF8)
  );
  sdi_frame_rx #(.WIDTH(5), .PARITY_EN(0)) u_dut5 (
    .CLK(CLK), .RN(RN), .D(D5), .bus(if5.master), .FERR(FERR5), .OVF(OVF5)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] q;
    logic        perr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // One bit time: launch on the falling edge, observe just after the rising edge.
  task automatic tick(input bit sel5, input logic d);
    @(negedge CLK);
    if (sel5) begin D5 = d; D8 = 1'b1; end
    else begin D8 = d; D5 = 1'b1; end
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] q, input logic perr);
    exp_t e;
    e.q = q;
    e.perr = perr;
    sb_q.push_back(e);
  endtask

  // Drives a whole frame; v_pre is VALID just before the stop edge.
  task automatic send(input bit sel5, input int w, input bit pen, input logic [31:0] data,
                      input bit par_flip, input logic stop_bit, input logic rdy_stop,
                      output logic v_pre);
    logic p;
    p = par_flip;
    tick(sel5, 1'b0);
    for (int i = 0; i < w; i++) begin
      tick(sel5, data[i]);
      p = p ^ data[i];
    end
    if (pen) tick(sel5, p);
    v_pre = sel5 ? if5.VALID : if8.VALID;
    if (sel5) if5.READY = rdy_stop;
    else if8.READY = rdy_stop;
    tick(sel5, stop_bit);
  endtask

  task automatic test_reset();
    RN = 1'b0;
    if8.READY = 1'b0;
    if5.READY = 1'b0;
    repeat (10) tick(1'b0, 1'b1);
    n_checks++; if (if8.Q !== 8'h00) begin n_errors++; $display("FAIL reset_q got=%h want=00", if8.Q); end
    n_checks++; if (if8.VALID !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b want=0", if8.VALID); end
    n_checks++; if (if8.PERR !== 1'b0) begin n_errors++; $display("FAIL reset_perr got=%b want=0", if8.PERR); end
    n_checks++; if (FERR8 !== 1'b0) begin n_errors++; $display("FAIL reset_ferr got=%b want=0", FERR8); end
    n_checks++; if (OVF8 !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b want=0", OVF8); end
    n_checks++; if (if5.VALID !== 1'b0 || if5.Q !== 5'h00) begin n_errors++; $display("FAIL reset_w5 got=%b/%h want=0/00", if5.VALID, if5.Q); end
    RN = 1'b1;
    tick(1'b0, 1'b1);
  endtask

  task automatic test_basic();
    logic vp;
    exp_t e;
    if8.READY = 1'b1;
    push_exp(32'h0000_00A5, 1'b0);
    send(1'b0, 8, 1'b1, 32'h0000_00A5, 1'b0, 1'b1, 1'b1, vp);
    n_checks++; if (vp !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid got=%b want=0", vp); end
    n_checks++; if (if8.VALID !== 1'b1) begin n_errors++; $display("FAIL basic_valid got=%b want=1", if8.VALID); end
    e = sb_q.pop_front();
    n_checks++; if (if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL basic_q got=%h want=%h", if8.Q, e.q[7:0]); end
    n_checks++; if (if8.PERR !== e.perr) begin n_errors++; $display("FAIL basic_perr got=%b want=%b", if8.PERR, e.perr); end
    tick(1'b0, 1'b1);
    n_checks++; if (if8.VALID !== 1'b0) begin n_errors++; $display("FAIL basic_one_cycle got=%b want=0", if8.VALID); end
  endtask

  task automatic test_parity_err();
    logic vp;
    exp_t e;
    if8.READY = 1'b1;
    push_exp(32'h0000_003C, 1'b1);
    send(1'b0, 8, 1'b1, 32'h0000_003C, 1'b1, 1'b1, 1'b1, vp);
    e = sb_q.pop_front();
    n_checks++; if (if8.VALID !== 1'b1) begin n_errors++; $display("FAIL perr_valid got=%b want=1", if8.VALID); end
    n_checks++; if (if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL perr_q got=%h want=%h", if8.Q, e.q[7:0]); end
    n_checks++; if (if8.PERR !== e.perr) begin n_errors++; $display("FAIL perr_flag got=%b want=%b", if8.PERR, e.perr); end
    tick(1'b0, 1'b1);
  endtask

  task automatic test_framing();
    logic vp;
    int nf;
    int nv;
    nf = 0;
    nv = 0;
    if8.READY = 1'b1;
    send(1'b0, 8, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b1, vp);
    n_checks++; if (FERR8 !== 1'b1) begin n_errors++; $display("FAIL ferr_pulse got=%b want=1", FERR8); end
    n_checks++; if (if8.VALID !== 1'b0) begin n_errors++; $display("FAIL ferr_valid got=%b want=0", if8.VALID); end
    repeat (20) begin tick(1'b0, 1'b0); nf += int'(FERR8); nv += int'(if8.VALID); end
    repeat (5) begin tick(1'b0, 1'b1); nf += int'(FERR8); nv += int'(if8.VALID); end
    n_checks++; if (nf !== 0) begin n_errors++; $display("FAIL ferr_extra got=%0d want=0", nf); end
    n_checks++; if (nv !== 0) begin n_errors++; $display("FAIL brk_frames got=%0d want=0", nv); end
  endtask

  task automatic test_overflow();
    logic vp;
    exp_t e;
    if8.READY = 1'b0;
    push_exp(32'h0000_0001, 1'b0);
    send(1'b0, 8, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, vp);
    e = sb_q.pop_front();
    n_checks++; if (if8.VALID !== 1'b1 || if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL ovf_first got=%b/%h want=1/%h", if8.VALID, if8.Q, e.q[7:0]); end
    send(1'b0, 8, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0, vp);
    n_checks++; if (if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL ovf_q_kept got=%h want=%h", if8.Q, e.q[7:0]); end
    n_checks++; if (OVF8 !== 1'b1) begin n_errors++; $display("FAIL ovf_set got=%b want=1", OVF8); end
    if8.READY = 1'b1;
    tick(1'b0, 1'b1);
    if8.READY = 1'b0;
    n_checks++; if (if8.VALID !== 1'b0) begin n_errors++; $display("FAIL ovf_consume got=%b want=0", if8.VALID); end
    n_checks++; if (OVF8 !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got=%b want=1", OVF8); end
    n_checks++; if (if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL ovf_q_hold got=%h want=%h", if8.Q, e.q[7:0]); end
  endtask

  task automatic test_back_to_back();
    logic vp;
    exp_t e;
    RN = 1'b0;
    tick(1'b0, 1'b1);
    RN = 1'b1;
    n_checks++; if (OVF8 !== 1'b0) begin n_errors++; $display("FAIL b2b_ovf_reset got=%b want=0", OVF8); end
    if8.READY = 1'b0;
    push_exp(32'h0000_0001, 1'b0);
    send(1'b0, 8, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b0, vp);
    e = sb_q.pop_front();
    n_checks++; if (if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL b2b_first_q got=%h want=%h", if8.Q, e.q[7:0]); end
    push_exp(32'h0000_0002, 1'b0);
    send(1'b0, 8, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b1, vp);
    e = sb_q.pop_front();
    n_checks++; if (if8.VALID !== 1'b1 || if8.Q !== e.q[7:0]) begin n_errors++; $display("FAIL b2b_second got=%b/%h want=1/%h", if8.VALID, if8.Q, e.q[7:0]); end
    n_checks++; if (OVF8 !== 1'b0) begin n_errors++; $display("FAIL b2b_ovf got=%b want=0", OVF8); end
    tick(1'b0, 1'b1);
    n_checks++; if (if8.VALID !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%b want=0", if8.VALID); end
  endtask

  task automatic test_reset_midframe();
    logic vp;
    exp_t e;
    int nv;
    nv = 0;
    if8.READY = 1'b1;
    tick(1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1);
    RN = 1'b0;
    tick(1'b0, 1'b1);
    RN = 1'b1;
    n_checks++; if (if8.VALID !== 1'b0 || if8.Q !== 8'h00) begin n_errors++; $display("FAIL mid_reset got=%b/%h want=0/00", if8.VALID, if8.Q); end
    repeat (6) begin tick(1'b0, 1'b1); nv += int'(if8.VALID); end
    n_checks++; if (nv !== 0) begin n_errors++; $display("FAIL mid_partial_delivered got=%0d want=0", nv); end
    push_exp(32'h0000_005A, 1'b0);
    send(1'b0, 8, 1'b1, 32'h0000_005A, 1'b0, 1'b1, 1'b1, vp);
    e = sb_q.pop_front();
    n_checks++; if (vp !== 1'b0 || if8.VALID !== 1'b1) begin n_errors++; $display("FAIL mid_valid got=%b%b want=01", vp, if8.VALID); end
    n_checks++; if (if8.Q !== e.q[7:0] || if8.PERR !== e.perr) begin n_errors++; $display("FAIL mid_word got=%h/%b want=%h/%b", if8.Q, if8.PERR, e.q[7:0], e.perr); end
    tick(1'b0, 1'b1);
  endtask

  task automatic test_w5_noparity();
    logic vp;
    exp_t e;
    if5.READY = 1'b1;
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b1);
    RN = 1'b0;
    tick(1'b1, 1'b1);
    RN = 1'b1;
    n_checks++; if (if5.VALID !== 1'b0 || if5.Q !== 5'h00) begin n_errors++; $display("FAIL w5_reset got=%b/%h want=0/00", if5.VALID, if5.Q); end
    repeat (3) tick(1'b1, 1'b1);
    push_exp(32'h0000_0013, 1'b0);
    send(1'b1, 5, 1'b0, 32'h0000_0013, 1'b0, 1'b1, 1'b1, vp);
    e = sb_q.pop_front();
    n_checks++; if (vp !== 1'b0 || if5.VALID !== 1'b1) begin n_errors++; $display("FAIL w5_latency got=%b%b want=01", vp, if5.VALID); end
    n_checks++; if (if5.Q !== e.q[4:0]) begin n_errors++; $display("FAIL w5_q got=%h want=%h", if5.Q, e.q[4:0]); end
    n_checks++; if (if5.PERR !== e.perr || OVF5 !== 1'b0 || FERR5 !== 1'b0) begin n_errors++; $display("FAIL w5_flags got=%b%b%b want=000", if5.PERR, OVF5, FERR5); end
    tick(1'b1, 1'b1);
    n_checks++; if (if5.VALID !== 1'b0) begin n_errors++; $display("FAIL w5_drain got=%b want=0", if5.VALID); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_framing();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_w5_noparity();
    n_checks++;
    if (sb_q.size() !== 0) begin n_errors++; $display("FAIL scoreboard_left got=%0d want=0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdi_frame_rx.md
# sdi_frame_rx

Synchronous serial frame receiver for the negative-edge launch path. It is the capture end of a one-bit-per-cycle serial link whose transmitter launches each bit on the falling edge of the shared clock. The block samples on the rising edge, giving half a cycle of margin. It deframes start/data/parity/stop, checks parity and framing, and presents each word through a single-entry valid/ready holding register.

## Interface
- `WIDTH`, default 8: data bits per frame, 1..32.
- `PARITY_EN`, default 1: 1 = even-parity bit present between data and stop; 0 = no parity bit.

- `CLK` in 1: clock; all state updates on the rising edge.
- `RN` in 1: reset, synchronous, active-low.
- `D` in 1: serial line; idles high; launched on falling edge of CLK.
- `Q` out WIDTH: received word; LSB = first data bit on the line.
- `VALID` out 1: Q/PERR hold an unconsumed word.
- `READY` in 1: consumer accepts; handshake = VALID & READY at a rising edge.
- `PERR` out 1: parity error for the word in Q; meaningful only while VALID=1.
- `FERR` out 1: one-cycle pulse, stop bit sampled 0.
- `OVF` out 1: sticky; a completed frame was dropped because the holding register was full.

## Operation
- Frame on D: start(0), WIDTH data bits LSB first, parity (if PARITY_EN), stop(1).
  - Frame length is WIDTH+3 bits with parity, WIDTH+2 without.
- FSM states and transitions:
  - IDLE: D=0 -> DATA with bit counter=0. D=1 -> stay.
  - DATA: shift D into the shift register at bit[cnt]. After bit WIDTH-1 -> PAR if PARITY_EN, else STOP.
  - PAR: capture D as received parity -> STOP.
  - STOP:
    - D=1 -> frame good -> IDLE; deliver the word.
    - D=0 -> pulse FERR, discard the word -> BRK.
  - BRK: wait until D=1 -> IDLE. Prevents a held-low line from generating frames.
- Parity check: PERR = XOR(data bits) XOR parity_bit; even parity means 0 is correct.
  - With PARITY_EN=0, PERR is always 0.
  - A word with a parity error is still delivered, with PERR=1.
- Delivery at the STOP edge with D=1:
  - If VALID=0, or VALID=1 with READY=1 on the same edge: load Q and PERR; VALID=1.
  - Otherwise: drop the word, set OVF=1; Q, PERR and VALID are unchanged.
- Consumption: handshake with no simultaneous load -> VALID=0. Q and PERR keep their old values.
- OVF is cleared only by reset.
- Reset (RN=0 at an edge):
  - State=IDLE, shift register and counter cleared, any partial frame discarded.
  - Q=0, VALID=0, PERR=0, FERR=0, OVF=0.
  - Reset has priority over every other event.

## Timing
- Edge k: IDLE samples start bit. Edges k+1..k+WIDTH: data bits. Edge k+WIDTH+1: parity. Edge k+WIDTH+2: stop.
- VALID, Q and PERR become visible immediately after the stop edge; all outputs are registered.
- Latency from the start-bit edge to VALID is WIDTH+2 cycles (WIDTH+1 without parity).
- Back-to-back frames need no idle gap: the start bit may be sampled at edge k+WIDTH+3.
- FERR is high for exactly the one cycle following the bad-stop edge.
- READY has no combinational path to any output.

## Test plan
Defaults apply unless stated: WIDTH=8, PARITY_EN=1.
- Reset with D=1 for 10 cycles -> Q=0x00; VALID, PERR, FERR and OVF all 0.
- READY=1, frame 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) -> VALID=1 for exactly one cycle, 10 cycles after the start edge; Q=0xA5, PERR=0.
- Frame 0x3C with parity bit 1 -> Q=0x3C, PERR=1, VALID=1.
- Frame 0x55 with stop bit 0, then D held 0 for 20 cycles, then D=1 -> FERR pulses once; VALID stays 0; no further frames or FERR pulses.
- READY=0, back-to-back frames 0x01 and 0x02 -> Q=0x01, VALID=1, OVF=1. Raise READY for one edge -> VALID=0, OVF stays 1.
  - Variant: second frame's stop edge coincides with the handshake -> Q=0x02, VALID=1, OVF=0.
- RN=0 for one edge after the 4th data bit of 0xFF, then full frame 0x5A -> no delivery of 0xFF; Q=0x5A, PERR=0.
  - Repeat with PARITY_EN=0 and WIDTH=5, frame 0x13 -> VALID asserted 6 cycles after the start edge.
